// File: rtl/pill_feeder.sv
// pill_feeder: paces pill-drop pulses per bottle and pauses for bottle swaps between bottles.
// Optional conveyor hold is enabled by defining PILL_FEEDER_HOLD_EN.
module pill_feeder #(
   parameter int GAP_CYC  = 4,
   parameter int SWAP_CYC = 8
) (
   input  logic       CLK,
   input  logic       RST_n,
   input  logic       start,
   input  logic       abort,
   input  logic       hold,
   input  logic [3:0] per_bot_L,
   input  logic [3:0] per_bot_H,
   input  logic [3:0] bot_num_L,
   input  logic [3:0] bot_num_H,
   output logic       pill,
   output logic       bot_done,
   output logic       busy,
   output logic       run_done,
   output logic       err,
   output logic [3:0] pill_cnt_L,
   output logic [3:0] pill_cnt_H,
   output logic [3:0] bot_cnt_L,
   output logic [3:0] bot_cnt_H
);

   typedef enum logic [2:0] {S_IDLE, S_GAP, S_DROP, S_SWAP, S_DONE} state_t;

   localparam logic [7:0] LP_GAP  = 8'(GAP_CYC);
   localparam logic [7:0] LP_SWAP = 8'(SWAP_CYC);

   state_t     r_state;
   logic [7:0] r_pace;
   logic [7:0] r_perBot;
   logic [7:0] r_botNum;
   logic [7:0] r_pillCnt;
   logic [7:0] r_botCnt;
   logic [7:0] w_pillNext;
   logic [7:0] w_botNext;
   logic       w_badSet;
   logic       w_hold;

   // Two-digit BCD increment that saturates at 99.
   function automatic logic [7:0] bcdInc(input logic [7:0] v);
      if (v == 8'h99)
         return v;
      if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

`ifdef PILL_FEEDER_HOLD_EN
   assign w_hold = hold;
`else
   assign w_hold = hold & 1'b0;
`endif

   assign w_pillNext = bcdInc(r_pillCnt);
   assign w_botNext  = bcdInc(r_botCnt);
   assign w_badSet   = (per_bot_L > 4'd9) || (per_bot_H > 4'd9) ||
                       (bot_num_L > 4'd9) || (bot_num_H > 4'd9) ||
                       ({per_bot_H, per_bot_L} == 8'h00) ||
                       ({bot_num_H, bot_num_L} == 8'h00);

   assign pill_cnt_L = r_pillCnt[3:0];
   assign pill_cnt_H = r_pillCnt[7:4];
   assign bot_cnt_L  = r_botCnt[3:0];
   assign bot_cnt_H  = r_botCnt[7:4];

   // Re-entering GAP from DROP or SWAP starts the pace at 1 so the pill period is GAP_CYC+1.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         r_state   <= S_IDLE;
         r_pace    <= '0;
         r_perBot  <= '0;
         r_botNum  <= '0;
         r_pillCnt <= '0;
         r_botCnt  <= '0;
         pill      <= 1'b0;
         bot_done  <= 1'b0;
         busy      <= 1'b0;
         run_done  <= 1'b0;
         err       <= 1'b0;
      end else begin
         pill     <= 1'b0;
         bot_done <= 1'b0;
         if (abort) begin
            r_state  <= S_IDLE;
            busy     <= 1'b0;
            run_done <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE, S_DONE: begin
                  if (start) begin
                     run_done <= 1'b0;
                     if (w_badSet) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                     end else begin
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        r_perBot  <= {per_bot_H, per_bot_L};
                        r_botNum  <= {bot_num_H, bot_num_L};
                        r_pillCnt <= '0;
                        r_botCnt  <= '0;
                        r_pace    <= '0;
                        r_state   <= S_GAP;
                     end
                  end
               end
               S_GAP: begin
                  if (!w_hold) begin
                     if (r_pace == LP_GAP) begin
                        r_state <= S_DROP;
                        pill    <= 1'b1;
                     end else begin
                        r_pace <= r_pace + 8'd1;
                     end
                  end
               end
               S_DROP: begin
                  r_pillCnt <= w_pillNext;
                  r_pace    <= 8'd1;
                  if (w_pillNext == r_perBot) begin
                     r_botCnt <= w_botNext;
                     bot_done <= 1'b1;
                     if (w_botNext == r_botNum) begin
                        r_state  <= S_DONE;
                        busy     <= 1'b0;
                        run_done <= 1'b1;
                     end else begin
                        r_state <= S_SWAP;
                     end
                  end else begin
                     r_state <= S_GAP;
                  end
               end
               S_SWAP: begin
                  if (!w_hold) begin
                     if (r_pace == LP_SWAP) begin
                        r_state   <= S_GAP;
                        r_pace    <= 8'd1;
                        r_pillCnt <= '0;
                     end else begin
                        r_pace <= r_pace + 8'd1;
                     end
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pill_feeder.sv
// tb_pill_feeder: directed self-checking bench for pill_feeder with default GAP_CYC=4, SWAP_CYC=8.
// Cycle k means the cycle after the k-th rising edge following the start sample.
module tb_pill_feeder;

   logic       CLK;
   logic       RST_n;
   logic       start;
   logic       abort;
   logic       hold;
   logic [3:0] per_bot_L;
   logic [3:0] per_bot_H;
   logic [3:0] bot_num_L;
   logic [3:0] bot_num_H;
   logic       pill;
   logic       bot_done;
   logic       busy;
   logic       run_done;
   logic       err;
   logic [3:0] pill_cnt_L;
   logic [3:0] pill_cnt_H;
   logic [3:0] bot_cnt_L;
   logic [3:0] bot_cnt_H;

   int nCompared;
   int nMismatched;
   int cyc;
   int e0;
   int pillQ[$];
   int botQ[$];
   int expBasicPill[6] = '{5, 10, 15, 28, 33, 38};
   int expBasicBot[2]  = '{16, 39};

   pill_feeder #(.GAP_CYC(4), .SWAP_CYC(8)) dut (
      .CLK        (CLK),
      .RST_n      (RST_n),
      .start      (start),
      .abort      (abort),
      .hold       (hold),
      .per_bot_L  (per_bot_L),
      .per_bot_H  (per_bot_H),
      .bot_num_L  (bot_num_L),
      .bot_num_H  (bot_num_H),
      .pill       (pill),
      .bot_done   (bot_done),
      .busy       (busy),
      .run_done   (run_done),
      .err        (err),
      .pill_cnt_L (pill_cnt_L),
      .pill_cnt_H (pill_cnt_H),
      .bot_cnt_L  (bot_cnt_L),
      .bot_cnt_H  (bot_cnt_H)
   );

   // 10-unit clock; rising edges at 5, 15, 25, ...
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Rising-edge count plus a record of which cycle each pill/bot_done pulse appeared in.
   initial cyc = 0;
   always @(posedge CLK) cyc++;

   always @(negedge CLK) begin
      if (pill === 1'b1)
         pillQ.push_back(cyc);
      if (bot_done === 1'b1)
         botQ.push_back(cyc);
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nCompared++;
      assert (observed === expected) else begin
         nMismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drives setpoints and a one-cycle start; returns in cycle 0 with the pulse records cleared.
   task automatic applyStimulus(input logic [7:0] perBot, input logic [7:0] botNum);
      per_bot_H = perBot[7:4];
      per_bot_L = perBot[3:0];
      bot_num_H = botNum[7:4];
      bot_num_L = botNum[3:0];
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      e0 = cyc;
      pillQ.delete();
      botQ.delete();
   endtask

   task automatic gotoCycle(input int k);
      while (cyc - e0 < k)
         @(negedge CLK);
   endtask

   function automatic int pillAt(input int i);
      return (i < pillQ.size()) ? pillQ[i] - e0 : -1;
   endfunction

   function automatic int botAt(input int i);
      return (i < botQ.size()) ? botQ[i] - e0 : -1;
   endfunction

   initial begin
      int expHoldPill;
      nCompared   = 0;
      nMismatched = 0;
      e0          = 0;
      RST_n       = 1'b0;
      start       = 1'b0;
      abort       = 1'b0;
      hold        = 1'b0;
      per_bot_L   = 4'd0;
      per_bot_H   = 4'd0;
      bot_num_L   = 4'd0;
      bot_num_H   = 4'd0;
`ifdef PILL_FEEDER_HOLD_EN
      expHoldPill = 20;
`else
      expHoldPill = 10;
`endif

      repeat (2) @(negedge CLK);
      checkOutput("rst_pill", pill, 1'b0);
      checkOutput("rst_botdone", bot_done, 1'b0);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_rundone", run_done, 1'b0);
      checkOutput("rst_err", err, 1'b0);
      checkOutput("rst_pillcnt", {pill_cnt_H, pill_cnt_L}, 8'h00);
      checkOutput("rst_botcnt", {bot_cnt_H, bot_cnt_L}, 8'h00);
      RST_n = 1'b1;
      repeat (2) @(negedge CLK);
      checkOutput("idle_busy", busy, 1'b0);

      // Basic run: 3 pills per bottle, 2 bottles.
      applyStimulus(8'h03, 8'h02);
      checkOutput("basic_busy_c0", busy, 1'b1);
      gotoCycle(20);
      checkOutput("basic_swap_pillcnt", {pill_cnt_H, pill_cnt_L}, 8'h03);
      checkOutput("basic_swap_botcnt", {bot_cnt_H, bot_cnt_L}, 8'h01);
      checkOutput("basic_swap_busy", busy, 1'b1);
      gotoCycle(24);
      checkOutput("basic_after_swap_pillcnt", {pill_cnt_H, pill_cnt_L}, 8'h00);
      gotoCycle(38);
      checkOutput("basic_rundone_c38", run_done, 1'b0);
      gotoCycle(39);
      checkOutput("basic_rundone_c39", run_done, 1'b1);
      checkOutput("basic_botdone_c39", bot_done, 1'b1);
      checkOutput("basic_busy_c39", busy, 1'b0);
      gotoCycle(45);
      checkOutput("basic_pill_count", pillQ.size(), 6);
      for (int i = 0; i < 6; i++)
         checkOutput($sformatf("basic_pill%0d_cycle", i), pillAt(i), expBasicPill[i]);
      checkOutput("basic_bot_count", botQ.size(), 2);
      for (int i = 0; i < 2; i++)
         checkOutput($sformatf("basic_bot%0d_cycle", i), botAt(i), expBasicBot[i]);
      checkOutput("basic_final_botcnt", {bot_cnt_H, bot_cnt_L}, 8'h02);
      checkOutput("basic_final_pillcnt", {pill_cnt_H, pill_cnt_L}, 8'h03);
      checkOutput("basic_final_rundone", run_done, 1'b1);

      // BCD carry: 12 pills in one bottle, restarted from DONE.
      applyStimulus(8'h12, 8'h01);
      checkOutput("bcd_clear_pillcnt", {pill_cnt_H, pill_cnt_L}, 8'h00);
      checkOutput("bcd_clear_botcnt", {bot_cnt_H, bot_cnt_L}, 8'h00);
      checkOutput("bcd_rundone_c0", run_done, 1'b0);
      gotoCycle(50);
      checkOutput("bcd_pillcnt_09", {pill_cnt_H, pill_cnt_L}, 8'h09);
      gotoCycle(51);
      checkOutput("bcd_pillcnt_10", {pill_cnt_H, pill_cnt_L}, 8'h10);
      gotoCycle(61);
      checkOutput("bcd_final_pillcnt", {pill_cnt_H, pill_cnt_L}, 8'h12);
      checkOutput("bcd_final_botcnt", {bot_cnt_H, bot_cnt_L}, 8'h01);
      checkOutput("bcd_rundone", run_done, 1'b1);
      gotoCycle(65);
      checkOutput("bcd_pill_count", pillQ.size(), 12);

      // Rejected setpoints, then a valid start that clears err.
      applyStimulus(8'h00, 8'h02);
      checkOutput("rej00_err", err, 1'b1);
      checkOutput("rej00_busy", busy, 1'b0);
      checkOutput("rej00_rundone", run_done, 1'b0);
      gotoCycle(10);
      checkOutput("rej00_no_pill", pillQ.size(), 0);
      applyStimulus(8'h03, 8'h0A);
      checkOutput("rejA_err", err, 1'b1);
      checkOutput("rejA_busy", busy, 1'b0);
      applyStimulus(8'h03, 8'h02);
      checkOutput("valid_clears_err", err, 1'b0);
      checkOutput("valid_busy", busy, 1'b1);

      // Abort sampled at the end of the 2nd SWAP cycle (cycle 17).
      gotoCycle(17);
      abort = 1'b1;
      @(negedge CLK);
      abort = 1'b0;
      checkOutput("abort_busy", busy, 1'b0);
      checkOutput("abort_pillcnt", {pill_cnt_H, pill_cnt_L}, 8'h03);
      checkOutput("abort_botcnt", {bot_cnt_H, bot_cnt_L}, 8'h01);
      checkOutput("abort_err", err, 1'b0);
      checkOutput("abort_rundone", run_done, 1'b0);
      gotoCycle(40);
      checkOutput("abort_pill_count", pillQ.size(), 3);
      checkOutput("abort_busy_late", busy, 1'b0);

      // Hold for 10 samples during the GAP before the second pill.
      applyStimulus(8'h02, 8'h01);
      gotoCycle(6);
      hold = 1'b1;
      gotoCycle(16);
      hold = 1'b0;
      gotoCycle(30);
      checkOutput("hold_pill_count", pillQ.size(), 2);
      checkOutput("hold_pill0_cycle", pillAt(0), 5);
      checkOutput("hold_pill1_cycle", pillAt(1), expHoldPill);
      checkOutput("hold_bot_cycle", botAt(0), expHoldPill + 1);
      checkOutput("hold_rundone", run_done, 1'b1);

      // Asynchronous reset in the middle of a DROP cycle.
      applyStimulus(8'h03, 8'h02);
      gotoCycle(10);
      checkOutput("rstmid_pill_before", pill, 1'b1);
      checkOutput("rstmid_pillcnt_before", {pill_cnt_H, pill_cnt_L}, 8'h01);
      #2 RST_n = 1'b0;
      #1;
      checkOutput("rstmid_pill", pill, 1'b0);
      checkOutput("rstmid_busy", busy, 1'b0);
      checkOutput("rstmid_pillcnt", {pill_cnt_H, pill_cnt_L}, 8'h00);
      checkOutput("rstmid_botcnt", {bot_cnt_H, bot_cnt_L}, 8'h00);
      start = 1'b1;
      repeat (3) @(negedge CLK);
      checkOutput("rstmid_start_ignored", busy, 1'b0);
      start = 1'b0;
      RST_n = 1'b1;
      pillQ.delete();
      repeat (10) @(negedge CLK);
      checkOutput("rstmid_idle_busy", busy, 1'b0);
      checkOutput("rstmid_no_pill", pillQ.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/pill_feeder.md
# pill_feeder

Dispenser-side controller for the bottle-filling counter: it generates the pill-drop pulses that the counting path consumes, pacing them per bottle and pausing for a bottle swap between bottles. Setpoints use the same two-digit BCD format as the counter's set inputs (00–99). Its BCD progress counters can drive the same display pages. It runs in the divided `CLK` domain, alongside the counting modules.

## Interface
- `GAP_CYC`, default 4: idle cycles before each pill pulse; valid range 1–255.
- `SWAP_CYC`, default 8: cycles spent in bottle swap between bottles; valid range 1–255.

- `CLK` in 1: single clock; all logic is rising-edge.
- `RST_n` in 1: asynchronous active-low reset.
- `start` in 1: a high sample in IDLE or DONE starts a run.
- `abort` in 1: a high sample ends any run immediately.
- `hold` in 1: conveyor hold; pauses pacing while high.
- `per_bot_L`, `per_bot_H` in 4 each: BCD pills per bottle (units, tens).
- `bot_num_L`, `bot_num_H` in 4 each: BCD bottles per run.
- `pill` out 1: one-cycle pulse per dropped pill.
- `bot_done` out 1: one-cycle pulse per completed bottle.
- `busy` out 1: high in GAP, DROP or SWAP.
- `run_done` out 1: level; high in DONE.
- `err` out 1: setpoint rejected at start; held until the next start sample.
- `pill_cnt_L`, `pill_cnt_H` out 4 each: BCD pills in the current bottle.
- `bot_cnt_L`, `bot_cnt_H` out 4 each: BCD bottles completed.

## Operation
- FSM states: IDLE, GAP, DROP, SWAP, DONE. Reset enters IDLE.
- Output reset values: `pill`, `bot_done`, `busy`, `run_done` and `err` are 0; all counters are 00.
- Start check, on `start` in IDLE or DONE:
  - If any digit is >9, or either setpoint is 00: set `err`=1 and go to IDLE.
  - Otherwise: latch both setpoints, clear `err` and both counters, go to GAP with the pacing counter at 0.
- GAP: the pacing counter counts up to `GAP_CYC`, then the FSM goes to DROP.
- DROP (one cycle): `pill`=1. At the exit edge, `pill_cnt` increments in BCD (09→10, 99 max).
  - If the new count equals `per_bot`: `bot_cnt` increments and `bot_done` pulses in the next cycle.
    - If the new `bot_cnt` equals `bot_num`, go to DONE.
    - Otherwise, go to SWAP.
  - Otherwise: return to GAP.
- SWAP: lasts `SWAP_CYC` cycles. `pill_cnt` keeps showing the full count. At the exit edge, `pill_cnt` clears to 00 and the FSM goes to GAP.
- DONE: counters are frozen and `run_done`=1. A new `start` restarts.
- `abort` takes priority over every other input. Next state is IDLE; `pill` and `bot_done` are forced 0; counters keep their values; `err` is unchanged.
- `start` in GAP, DROP or SWAP is ignored. Setpoint inputs are ignored after they are latched.

## Timing
- Start sampled at edge E0. The first `pill` is high in cycle E0+`GAP_CYC`+1, i.e. the cycle after that edge.
- Pill period within a bottle: `GAP_CYC`+1 cycles.
- Between bottles:
  - `bot_done` is high in the cycle after the last pill of a bottle.
  - The first pill of the next bottle follows `SWAP_CYC`+`GAP_CYC`+1 cycles after the last pill.
- `run_done` rises in the same cycle as the final `bot_done`.
- All outputs are registered; there are no combinational input-to-output paths.
- Async `RST_n` mid-run: outputs take their reset values immediately. The FSM leaves IDLE only on a `start` sampled after `RST_n` deasserts.

## Configuration
- `PILL_FEEDER_HOLD_EN` defined:
  - While `hold`=1, the GAP and SWAP counters freeze and DROP is not entered.
  - A `hold` rising in DROP still completes that pill.
  - Resumes with the remaining count when `hold` returns to 0.
- `PILL_FEEDER_HOLD_EN` undefined: the `hold` port is present but ignored, and pacing is unconditional.

## Test plan
- Basic run. GAP=4, SWAP=8, per_bot=03, bot_num=02, start at E0:
  - 6 `pill` pulses in total, first in cycle E0+5, at period 5.
  - `bot_done` in cycles E0+16 and E0+39; `run_done` from E0+39.
  - Final counters: `bot_cnt`=02, `pill_cnt`=03.
- BCD carry. per_bot=12, bot_num=01: `pill_cnt` steps 09→10 (H=1, L=0) on the 10th pill, then ends at 12 with `run_done`=1.
- Rejects:
  - per_bot=00 → `err`=1, `busy`=0, no `pill`.
  - bot_num_L=0xA → `err`=1.
  - A following valid start clears `err`.
- Abort: abort in the 2nd SWAP cycle → IDLE next cycle, `busy`=0, no further `pill`, counters held at 03/01.
- Hold (macro on): `hold`=1 for 10 cycles during GAP delays the next pill by exactly 10 cycles. With the macro off, the pill timing is unchanged.
- Reset: `RST_n`=0 during DROP → `pill` drops immediately, all counters read 00, `start` is ignored while `RST_n`=0.
